// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared word width, NOP encoding and fetch FSM states
package fetch_pc_unit_pkg;
  localparam int DEF_WORD_LEN = 32;
  localparam logic [31:0] DEF_NOP = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/fetch_pc_unit_pc_branch_adder.sv
// pc_branch_adder: branch target = base + word offset, wrapping mod 2^WORD_LEN
module pc_branch_adder import fetch_pc_unit_pkg::*; #(
  parameter int WORD_LEN = DEF_WORD_LEN
) (
  input  logic [WORD_LEN-1:0] base,
  input  logic [WORD_LEN-1:0] offset,
  output logic [WORD_LEN-1:0] target
);
  assign target = base + (offset << 2);
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, single-outstanding imem fetch FSM with skid buffer, IF/ID register
module fetch_pc_unit import fetch_pc_unit_pkg::*; #(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0,
  parameter logic [WORD_LEN-1:0] NOP_INSTR = WORD_LEN'(DEF_NOP)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                STALL,
  input  logic                BRANCH_CONDITION,
  input  logic [WORD_LEN-1:0] BRANCH_BASE_PC,
  input  logic [WORD_LEN-1:0] BRANCH_OFFSET,
  output logic                IMEM_REQ,
  output logic [WORD_LEN-1:0] IMEM_ADDR,
  input  logic [WORD_LEN-1:0] IMEM_RDATA,
  input  logic                IMEM_VALID,
  output logic [WORD_LEN-1:0] IF_ID_PC_PLUS4,
  output logic [WORD_LEN-1:0] IF_ID_INSTR,
  output logic                IF_ID_VALID,
  output logic                FLUSH
);
  fetch_state_e st, nxt;
  logic [WORD_LEN-1:0] pc, pc_plus4, target, skid;
  logic load, cap;
  pc_branch_adder #(.WORD_LEN(WORD_LEN)) u_adder (
    .base(BRANCH_BASE_PC),
    .offset(BRANCH_OFFSET),
    .target(target)
  );
  assign pc_plus4 = pc + WORD_LEN'(4);
  assign IMEM_ADDR = pc;
  // a redirect cycle never issues the stale-PC fetch
  assign IMEM_REQ = !RST && st == FETCH_REQ && !STALL && !BRANCH_CONDITION;
  assign FLUSH = !RST && BRANCH_CONDITION;
  always_comb begin
    nxt = st;
    load = 1'b0;
    cap = 1'b0;
    if (BRANCH_CONDITION)
      nxt = (st == FETCH_WAIT || st == FETCH_DRAIN) && !IMEM_VALID ? FETCH_DRAIN : FETCH_REQ;
    else
      case (st)
        FETCH_REQ:   nxt = STALL ? FETCH_REQ : FETCH_WAIT;
        FETCH_WAIT: begin
          nxt = IMEM_VALID ? (STALL ? FETCH_HOLD : FETCH_REQ) : FETCH_WAIT;
          load = IMEM_VALID && !STALL;
          cap = IMEM_VALID && STALL;
        end
        FETCH_HOLD: begin
          nxt = STALL ? FETCH_HOLD : FETCH_REQ;
          load = !STALL;
        end
        FETCH_DRAIN: nxt = IMEM_VALID ? FETCH_REQ : FETCH_DRAIN;
      endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= FETCH_REQ;
      pc <= RESET_PC;
      skid <= '0;
      IF_ID_PC_PLUS4 <= '0;
      IF_ID_INSTR <= NOP_INSTR;
      IF_ID_VALID <= 1'b0;
    end else begin
      st <= nxt;
      if (BRANCH_CONDITION) pc <= target;
      else if (load) pc <= pc_plus4;
      if (cap) skid <= IMEM_RDATA;
      if (load) begin
        IF_ID_PC_PLUS4 <= pc_plus4;
        IF_ID_INSTR <= st == FETCH_HOLD ? skid : IMEM_RDATA;
        IF_ID_VALID <= 1'b1;
      end else if (BRANCH_CONDITION || !STALL) begin
        IF_ID_INSTR <= NOP_INSTR;
        IF_ID_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: transaction-level fetch model plus variable-latency memory, random and directed stimulus
module tb_fetch_pc_unit;
  logic CLK = 1'b0, RST = 1'b0, STALL = 1'b0, BRANCH_CONDITION = 1'b0, IMEM_VALID = 1'b0;
  logic [31:0] BRANCH_BASE_PC = '0, BRANCH_OFFSET = '0, IMEM_RDATA = '0;
  logic IMEM_REQ, IF_ID_VALID, FLUSH;
  logic [31:0] IMEM_ADDR, IF_ID_PC_PLUS4, IF_ID_INSTR;
  int vec = 0, err = 0;
  always #5 CLK = ~CLK;
  fetch_pc_unit dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BRANCH_CONDITION(BRANCH_CONDITION),
    .BRANCH_BASE_PC(BRANCH_BASE_PC), .BRANCH_OFFSET(BRANCH_OFFSET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .IMEM_VALID(IMEM_VALID),
    .IF_ID_PC_PLUS4(IF_ID_PC_PLUS4), .IF_ID_INSTR(IF_ID_INSTR), .IF_ID_VALID(IF_ID_VALID), .FLUSH(FLUSH)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a3c_0000;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // model: pc, whether a fetch is in flight, whether it is to be discarded, a held instruction
  logic [31:0] m_pc = '0, m_hdat = '0, e_pc4 = '0, e_instr = '0;
  logic m_out = 1'b0, m_drop = 1'b0, m_held = 1'b0, e_v = 1'b0, m_ld = 1'b0, c_req = 1'b0;
  task automatic take(input logic [31:0] d);
    m_ld = 1'b1;
    e_instr = d;
    e_pc4 = m_pc + 32'd4;
    e_v = 1'b1;
    m_pc = m_pc + 32'd4;
  endtask
  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_pc = '0; m_out = 0; m_drop = 0; m_held = 0; e_pc4 = '0; e_instr = '0; e_v = 0;
    end else if (BRANCH_CONDITION) begin
      m_pc = BRANCH_BASE_PC + BRANCH_OFFSET * 32'd4;
      e_v = 0; e_instr = '0; m_held = 0;
      m_drop = m_out && !IMEM_VALID;
      m_out = m_drop;
    end else begin
      m_ld = 1'b0;
      if (m_out && IMEM_VALID) begin
        if (!m_drop && !STALL) take(IMEM_RDATA);
        else if (!m_drop) begin m_held = 1; m_hdat = IMEM_RDATA; end
        m_out = 0; m_drop = 0;
      end else if (m_held && !STALL) begin
        take(m_hdat);
        m_held = 0;
      end else if (!m_out && !m_held && !STALL) m_out = 1;
      if (!m_ld && !STALL) begin e_v = 0; e_instr = '0; end
    end
  end
  logic s_req = 1'b0, mem_busy = 1'b0;
  logic [31:0] s_addr = '0, mem_addr = '0;
  int mem_cnt = 0, lat_mode = 1;
  initial forever begin
    @(posedge CLK);
    if (RST) mem_busy = 0;
    else begin
      if (mem_busy && IMEM_VALID) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (s_req) begin
        mem_busy = 1;
        mem_addr = s_addr;
        mem_cnt = (lat_mode == 0 ? int'($urandom_range(1, 3)) : lat_mode) - 1;
      end
    end
  end
  initial forever begin
    @(negedge CLK);
    s_req = IMEM_REQ;
    s_addr = IMEM_ADDR;
    c_req = !RST && !m_out && !m_held && !STALL && !BRANCH_CONDITION;
    chk("imem_req", {31'd0, IMEM_REQ}, {31'd0, c_req});
    if (c_req) chk("imem_addr", IMEM_ADDR, m_pc);
    chk("flush", {31'd0, FLUSH}, {31'd0, !RST && BRANCH_CONDITION});
    chk("if_id_valid", {31'd0, IF_ID_VALID}, {31'd0, e_v});
    chk("if_id_instr", IF_ID_INSTR, e_instr);
    chk("if_id_pc_plus4", IF_ID_PC_PLUS4, e_pc4);
  end
  task automatic drive(input logic st, input logic br, input logic [31:0] base, input logic [31:0] off);
    @(posedge CLK); #1;
    STALL = st; BRANCH_CONDITION = br; BRANCH_BASE_PC = base; BRANCH_OFFSET = off;
    IMEM_VALID = mem_busy && mem_cnt == 0;
    IMEM_RDATA = IMEM_VALID ? word(mem_addr) : $urandom;
  endtask
  initial begin
    logic [31:0] off;
    #1 RST = 1'b1;
    repeat (2) @(posedge CLK);
    drive(0, 0, 0, 0); RST = 1'b0;
    @(negedge CLK); chk("lit_first_addr", IMEM_ADDR, 32'h0); chk("lit_first_req", {31'd0, IMEM_REQ}, 32'd1);
    drive(0, 0, 0, 0);
    @(negedge CLK); chk("lit_wait_bubble", {31'd0, IF_ID_VALID}, 32'd0);
    drive(0, 0, 0, 0);
    @(negedge CLK);
    chk("lit_pc4_0", IF_ID_PC_PLUS4, 32'd4); chk("lit_instr_0", IF_ID_INSTR, word(32'd0));
    chk("lit_valid_0", {31'd0, IF_ID_VALID}, 32'd1); chk("lit_addr_4", IMEM_ADDR, 32'd4);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge CLK); chk("lit_addr_8", IMEM_ADDR, 32'd8);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge CLK); chk("lit_hold_noreq", {31'd0, IMEM_REQ}, 32'd0); chk("lit_hold_ifid", {31'd0, IF_ID_VALID}, 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 1, 32'h20, 32'hFFFF_FFFC);
    @(negedge CLK);
    chk("lit_skid_instr", IF_ID_INSTR, word(32'd8)); chk("lit_skid_pc4", IF_ID_PC_PLUS4, 32'd12);
    chk("lit_br_flush", {31'd0, FLUSH}, 32'd1); chk("lit_br_noreq", {31'd0, IMEM_REQ}, 32'd0);
    lat_mode = 3;
    drive(0, 0, 0, 0);
    @(negedge CLK);
    chk("lit_br_target", IMEM_ADDR, 32'h10); chk("lit_br_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("lit_br_squash", {31'd0, IF_ID_VALID}, 32'd0);
    drive(0, 1, 32'h100, 32'd3);
    drive(0, 0, 0, 0);
    @(negedge CLK); chk("lit_drain_noreq", {31'd0, IMEM_REQ}, 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge CLK);
    chk("lit_drain_target", IMEM_ADDR, 32'h10C); chk("lit_drain_req", {31'd0, IMEM_REQ}, 32'd1);
    chk("lit_drain_dropped", {31'd0, IF_ID_VALID}, 32'd0);
    drive(1, 1, 32'h40, 32'd1);
    @(negedge CLK); chk("lit_stall_br_flush", {31'd0, FLUSH}, 32'd1);
    repeat (3) drive(0, 0, 0, 0);
    @(negedge CLK); chk("lit_stall_br_target", IMEM_ADDR, 32'h44); chk("lit_stall_br_req", {31'd0, IMEM_REQ}, 32'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0); RST = 1'b1;
    @(negedge CLK);
    chk("lit_rst_req", {31'd0, IMEM_REQ}, 32'd0); chk("lit_rst_pc4", IF_ID_PC_PLUS4, 32'd0);
    chk("lit_rst_valid", {31'd0, IF_ID_VALID}, 32'd0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0); RST = 1'b0; IMEM_VALID = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK); chk("lit_rst_addr", IMEM_ADDR, 32'h0); chk("lit_rst_req_back", {31'd0, IMEM_REQ}, 32'd1);
    drive(0, 0, 0, 0);
    @(negedge CLK); chk("lit_late_ignored", {31'd0, IF_ID_VALID}, 32'd0);
    lat_mode = 0;
    repeat (4000) begin
      off = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      if ($urandom_range(0, 399) == 0) begin
        drive(0, 0, 0, 0); RST = 1'b1;
        drive(0, 0, 0, 0); RST = 1'b0;
      end else
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom, off);
    end
    drive(0, 0, 0, 0);
    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
